// File: rtl/chacha_keystream_xor_if.sv
// Message, keystream and output handshake bundle for chacha_keystream_xor.
// The slave modport is the XOR block; the master modport is its environment.
interface chacha_keystream_xor_if #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 512
);
  logic                   init;
  logic [31:0]            init_count;
  logic                   blk_req;
  logic [31:0]            blk_count;
  logic                   ks_valid;
  logic [BLOCK_WIDTH-1:0] ks_block;
  logic                   ks_ready;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   out_ready;
  logic                   err;

  modport slave (
    input  init, init_count, ks_valid, ks_block, in_valid, in_data, in_last, out_ready,
    output blk_req, blk_count, ks_ready, in_ready, out_valid, out_data, out_last, err
  );

  modport master (
    output init, init_count, ks_valid, ks_block, in_valid, in_data, in_last, out_ready,
    input  blk_req, blk_count, ks_ready, in_ready, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/chacha_keystream_xor.sv
// XORs a 32-bit message stream with 512-bit keystream blocks fetched by block counter.
// Define CHACHA_XOR_WRAP_ERR_EN to trap block-counter wrap (sticky err, HALT state).
module chacha_keystream_xor #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  chacha_keystream_xor_if.slave bus
);

  localparam int WORDS = BLOCK_WIDTH / WIDTH;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [31:0]            count_r;
  logic [IDX_W-1:0]       idx_r;
  logic [BLOCK_WIDTH-1:0] ks_r;
  logic                   out_valid_r;
  logic [WIDTH-1:0]       out_data_r;
  logic                   out_last_r;
  logic                   in_ready_s;
  logic                   in_fire_s;
  logic                   ks_fire_s;
  logic                   end_blk_s;
  logic                   cnt_step_s;
  logic                   wrap_hit_s;
  logic [WIDTH-1:0]       ks_word_s;

  assign in_ready_s = (state_r == ST_STREAM) && !bus.init && (!out_valid_r || bus.out_ready);
  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign ks_fire_s  = (state_r == ST_LOAD) && bus.ks_valid && !bus.init;
  assign end_blk_s  = in_fire_s && (bus.in_last || (idx_r == IDX_W'(WORDS - 1)));
  assign ks_word_s  = ks_r[int'(idx_r) * WIDTH +: WIDTH];

`ifdef CHACHA_XOR_WRAP_ERR_EN
  assign wrap_hit_s = (count_r == 32'hFFFF_FFFF);
`else
  assign wrap_hit_s = 1'b0;
`endif

  assign bus.blk_req   = (state_r == ST_LOAD);
  assign bus.ks_ready  = (state_r == ST_LOAD);
  assign bus.blk_count = count_r;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state; init overrides every state and drops the captured block
  always_comb begin
    state_nxt_s = state_r;
    cnt_step_s  = 1'b0;
    if (bus.init) begin
      state_nxt_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (bus.ks_valid) begin
            state_nxt_s = ST_STREAM;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end
        ST_STREAM: begin
          if (end_blk_s) begin
            cnt_step_s = 1'b1;
            if (wrap_hit_s) begin
              state_nxt_s = ST_HALT;
            end else if (bus.in_last) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_LOAD;
            end
          end else begin
            state_nxt_s = ST_STREAM;
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Block counter, keystream capture and word index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 32'd0;
      idx_r   <= {IDX_W{1'b0}};
      ks_r    <= {BLOCK_WIDTH{1'b0}};
    end else begin
      if (bus.init) begin
        count_r <= bus.init_count;
      end else if (cnt_step_s) begin
        count_r <= count_r + 32'd1;
      end
      if (ks_fire_s) begin
        ks_r  <= bus.ks_block;
        idx_r <= {IDX_W{1'b0}};
      end else if (in_fire_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // Output register: a fresh input word replaces the held one even while it drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      if (in_fire_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.in_data ^ ks_word_s;
        out_last_r  <= bus.in_last;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef CHACHA_XOR_WRAP_ERR_EN
  logic err_r;

  // Sticky wrap error, cleared only by init
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      if (bus.init) begin
        err_r <= 1'b0;
      end else if (cnt_step_s && wrap_hit_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Scoreboard bench for chacha_keystream_xor: random messages and keystream timing,
// expected words derived from block number = counter + word/16 within a message.
module tb_chacha_keystream_xor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chacha_keystream_xor_if bus();

  chacha_keystream_xor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef CHACHA_XOR_WRAP_ERR_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [31:0] blk_q[$];
  logic [31:0] m_cnt;
  int          m_pos;
  bit          m_fresh;
  bit          simple_mode = 1'b0;
  int          rdy_mode = 2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ks_word(input logic [31:0] c, input int i);
    logic [31:0] w;
    if (simple_mode) w = 32'h1000_0000 + 32'(i);
    else w = (c * 32'h9E37_79B1) ^ (32'h0101_0101 * 32'(i + 1)) ^ {c[15:0], c[31:16]};
    return w;
  endfunction

  function automatic logic [511:0] build_block(input logic [31:0] c);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = ks_word(c, i);
    return b;
  endfunction

  // Keystream source: answers requests after random delays, checks requested block numbers
  initial begin
    bus.ks_valid = 1'b0;
    bus.ks_block = 512'd0;
    forever begin
      @(negedge clk);
      if (!reset && bus.blk_req && $urandom_range(0, 2) != 0) begin
        bus.ks_valid = 1'b1;
        bus.ks_block = build_block(bus.blk_count);
        if (blk_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL blk_unexpected: got request for %h, expected none", bus.blk_count);
        end else begin
          chk("blk_count", bus.blk_count, blk_q.pop_front());
        end
      end else begin
        bus.ks_valid = 1'b0;
      end
    end
  end

  // Downstream ready: random, held low, or held high
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_unexpected: got word %h, expected none", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, exp_q.pop_front());
          chk("out_last", 32'(bus.out_last), 32'(exp_last_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic pulse_init(input logic [31:0] v);
    @(posedge clk);
    #1;
    bus.init       = 1'b1;
    bus.init_count = v;
    m_cnt   = v;
    m_pos   = 0;
    m_fresh = 1'b0;
    blk_q.push_back(v);
    @(posedge clk);
    #1;
    bus.init = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    int t;
    if (m_fresh) begin
      blk_q.push_back(m_cnt);
      m_fresh = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 2000) begin
        n_chk++;
        n_fail++;
        $display("FAIL in_ready_timeout: got no in_ready, expected transfer of %h", d);
        bus.in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(d ^ ks_word(m_cnt, m_pos));
    exp_last_q.push_back(last);
    m_pos++;
    if (last || m_pos == 16) begin
      m_cnt = m_cnt + 32'd1;
      m_pos = 0;
      if (last) m_fresh = 1'b1;
      else if (!(WRAP_EN && m_cnt == 32'd0)) blk_q.push_back(m_cnt);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input int n, input bit zeros);
    for (int k = 0; k < n; k++) send_word(zeros ? 32'd0 : 32'($urandom), k == n - 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] snap;
    int          t;
    reset          = 1'b1;
    bus.init       = 1'b0;
    bus.init_count = 32'd0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'd0;
    bus.in_last    = 1'b0;
    m_cnt   = 32'd0;
    m_pos   = 0;
    m_fresh = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_blk_req", 32'(bus.blk_req), 32'd0);
    chk("rst_ks_ready", 32'(bus.ks_ready), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_blk_count", bus.blk_count, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // One block of zeros returns the raw keystream
    simple_mode = 1'b1;
    rdy_mode    = 2;
    pulse_init(32'd1);
    @(negedge clk);
    chk("t1_blk_req", 32'(bus.blk_req), 32'd1);
    chk("t1_blk_count", bus.blk_count, 32'd1);
    send_msg(16, 1'b1);
    drain();
    chk("t1_blk_count_end", bus.blk_count, 32'd2);
    chk("t1_idle_blk_req", 32'(bus.blk_req), 32'd0);
    simple_mode = 1'b0;

    // 20-word message spans blocks 5 and 6
    rdy_mode = 0;
    pulse_init(32'd5);
    send_msg(20, 1'b0);
    drain();
    chk("t2_blk_count_end", bus.blk_count, 32'd7);

    // Message started from IDLE uses the current counter
    send_msg(3, 1'b0);
    drain();
    chk("t3_blk_count_end", bus.blk_count, 32'd8);

    // Downstream stall mid-stream
    pulse_init(32'h100);
    fork
      send_msg(20, 1'b0);
      begin
        repeat (4) @(negedge clk);
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!bus.out_valid && t < 200);
        chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
        snap = bus.out_data;
        repeat (10) begin
          @(negedge clk);
          chk("t4_out_stable", bus.out_data, snap);
          chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
        end
        rdy_mode = 0;
      end
    join
    drain();

    // init mid-stream restarts at word 0 of the new block
    pulse_init(32'h20);
    for (int k = 0; k < 7; k++) send_word(32'($urandom), 1'b0);
    pulse_init(32'h40);
    @(negedge clk);
    chk("t5_blk_req", 32'(bus.blk_req), 32'd1);
    chk("t5_blk_count", bus.blk_count, 32'h40);
    send_msg(5, 1'b0);
    drain();

    // Block counter wrap
    pulse_init(32'hFFFF_FFFF);
    if (WRAP_EN) begin
      for (int k = 0; k < 16; k++) send_word(32'($urandom), 1'b0);
      drain();
      bus.in_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("t6_err", 32'(bus.err), 32'd1);
        chk("t6_halt_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t6_halt_blk_req", 32'(bus.blk_req), 32'd0);
      end
      bus.in_valid = 1'b0;
      pulse_init(32'd3);
      @(negedge clk);
      chk("t6_err_cleared", 32'(bus.err), 32'd0);
      send_msg(2, 1'b0);
      drain();
    end else begin
      send_msg(17, 1'b0);
      drain();
      chk("t6_blk_count_end", bus.blk_count, 32'd1);
      chk("t6_err", 32'(bus.err), 32'd0);
    end

    // Asynchronous reset discards a pending output word
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    pulse_init(32'd9);
    send_word(32'($urandom), 1'b0);
    @(negedge clk);
    chk("t7_pending", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t7_blk_count", bus.blk_count, 32'd0);
    chk("t7_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t7_blk_req", 32'(bus.blk_req), 32'd0);
    exp_q.delete();
    exp_last_q.delete();
    blk_q.delete();
    m_cnt   = 32'd0;
    m_pos   = 0;
    m_fresh = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rdy_mode = 0;
    send_msg(4, 1'b0);
    drain();
    chk("t7_blk_count_end", bus.blk_count, 32'd1);
    chk("blk_q_empty", 32'(blk_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
